// File: rtl/operand_fetch_pkg.sv
// Shared widths and register-file constants for the operand fetch slice.
package operand_fetch_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  function automatic logic reg_hit(input logic en, input logic [REG_AW-1:0] a,
                                   input logic [REG_AW-1:0] b);
    return en && (a == b);
  endfunction

endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// Three-source operand select: $0 guard, then MEM forward, WB forward, register file.
module fwd_mux
  import operand_fetch_pkg::*;
(
  input  logic [REG_AW-1:0] src_i,
  input  logic              mem_wr_i,
  input  logic [REG_AW-1:0] mem_dest_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              wb_wr_i,
  input  logic [REG_AW-1:0] wb_dest_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = rf_data_i;
    if (src_i == REG_ZERO)
      data_o = '0;
    else if (reg_hit(mem_wr_i, mem_dest_i, src_i))
      data_o = mem_data_i;
    else if (reg_hit(wb_wr_i, wb_dest_i, src_i))
      // WB write lands this cycle and is not yet visible on the read port.
      data_o = wb_data_i;
  end

endmodule

// File: rtl/operand_fetch.sv
// ID->EX operand fetch: forwarding select, load-use bubble insertion and ID/EX register.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [4:0]        id_dest,
  input  logic              id_is_load,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              id_stall,
  output logic [4:0]        rf_addr1,
  output logic [4:0]        rf_addr2,
  input  logic [31:0]       rf_data1,
  input  logic [31:0]       rf_data2,
  input  logic              mem_wr,
  input  logic [4:0]        mem_dest,
  input  logic [31:0]       mem_data,
  input  logic              wb_wr,
  input  logic [4:0]        wb_dest,
  input  logic [31:0]       wb_data,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              ex_valid,
  output logic [31:0]       ex_a,
  output logic [31:0]       ex_b,
  output logic [4:0]        ex_dest,
  output logic              ex_is_load,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  lu_stall_cnt
);

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
  logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
  logic              ex_load_q, ex_load_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] opa, opb;
  logic              lu;

  assign rf_addr1 = id_rs;
  assign rf_addr2 = id_rt;

  fwd_mux u_fwd_a (
    .src_i(id_rs), .mem_wr_i(mem_wr), .mem_dest_i(mem_dest), .mem_data_i(mem_data),
    .wb_wr_i(wb_wr), .wb_dest_i(wb_dest), .wb_data_i(wb_data), .rf_data_i(rf_data1),
    .data_o(opa)
  );

  fwd_mux u_fwd_b (
    .src_i(id_rt), .mem_wr_i(mem_wr), .mem_dest_i(mem_dest), .mem_data_i(mem_data),
    .wb_wr_i(wb_wr), .wb_dest_i(wb_dest), .wb_data_i(wb_data), .rf_data_i(rf_data2),
    .data_o(opb)
  );

  assign lu = id_valid && ex_valid_q && ex_load_q && (ex_dest_q != REG_ZERO) &&
              (reg_hit(id_use_rs, id_rs, ex_dest_q) || reg_hit(id_use_rt, id_rt, ex_dest_q));

  assign id_stall = (lu || ex_hold) && !flush;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_dest_d  = ex_dest_q;
    ex_load_d  = ex_load_q;
    ex_ctrl_d  = ex_ctrl_q;
    cnt_d      = cnt_q;
    if (flush || (!ex_hold && lu)) begin
      ex_valid_d = 1'b0;
      ex_a_d     = '0;
      ex_b_d     = '0;
      ex_dest_d  = '0;
      ex_load_d  = 1'b0;
      ex_ctrl_d  = '0;
      // Only a bubble that actually enters EX is counted.
      if (!flush && cnt_q != '1)
        cnt_d = cnt_q + CNT_W'(1);
    end else if (!ex_hold) begin
      ex_valid_d = id_valid;
      ex_a_d     = opa;
      ex_b_d     = opb;
      ex_dest_d  = id_dest;
      ex_load_d  = id_is_load;
      ex_ctrl_d  = id_ctrl;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_dest_q  <= '0;
      ex_load_q  <= 1'b0;
      ex_ctrl_q  <= '0;
      cnt_q      <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_dest_q  <= ex_dest_d;
      ex_load_q  <= ex_load_d;
      ex_ctrl_q  <= ex_ctrl_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_a         = ex_a_q;
  assign ex_b         = ex_b_q;
  assign ex_dest      = ex_dest_q;
  assign ex_is_load   = ex_load_q;
  assign ex_ctrl      = ex_ctrl_q;
  assign lu_stall_cnt = cnt_q;

endmodule
